alu_issue_queue: RTL and testbench

Command buffer and issue controller sitting directly upstream of the 3-bit-opcode, 16-bit-operand ALU. It accepts operand/opcode commands over a valid/ready handshake and queues them in a FIFO. It issues at most one command per cycle to the ALU's operandA/operandB/opCode inputs, then captures the ALU's registered 32-bit result and returns it with a sequence tag. It hides the ALU's one-cycle latency and lets a slower producer, such as a switch/UART front end, drive the ALU safely.

---
 rtl/alu_issue_queue_if.sv | 43 ++++
 rtl/alu_issue_queue.sv | 143 ++++++++++++++
 tb/tb_alu_issue_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// Command, ALU-side and result signals of alu_issue_queue.
// res_ready exists only when ALU_ISSUE_STALL_EN is defined.
`timescale 1ns/1ps
interface alu_issue_queue_if #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [15:0]            in_a;
    logic [15:0]            in_b;
    logic [2:0]             in_op;
    logic [15:0]            alu_a;
    logic [15:0]            alu_b;
    logic [2:0]             alu_op;
    logic [31:0]            alu_result;
    logic                   res_valid;
    logic [31:0]            res_data;
    logic [TAG_WIDTH-1:0]   res_tag;
    logic [$clog2(DEPTH):0] fifo_count;

`ifdef ALU_ISSUE_STALL_EN
    logic                   res_ready;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, res_ready,
        output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, fifo_count
    );
    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, res_ready,
        input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, fifo_count
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result,
        output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, fifo_count
    );
    modport master (
        output in_valid, in_a, in_b, in_op, alu_result,
        input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, fifo_count
    );
`endif
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO and issue controller in front of the 1-cycle-latency ALU.
// Define ALU_ISSUE_STALL_EN for a 2-entry result FIFO with res_ready backpressure.
`timescale 1ns/1ps
module alu_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    alu_issue_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [15:0]          memA  [DEPTH];
    logic [15:0]          memB  [DEPTH];
    logic [2:0]           memOp [DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [CNT_W-1:0]     count;
    logic [15:0]          lastA;
    logic [15:0]          lastB;
    logic [2:0]           lastOp;
    logic [TAG_WIDTH-1:0] tagCtr;
    logic [TAG_WIDTH-1:0] tag_p1;
    logic                 vld_p1;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 issue;
    logic                 creditOk;

    assign empty          = (count == '0);
    assign full           = (count == FULL_CNT);
    assign bus.in_ready   = !full && !rst;
    assign push           = bus.in_valid && bus.in_ready;
    assign issue          = !empty && creditOk;
    assign bus.fifo_count = count;

    // p0: FIFO head drives the ALU; an empty FIFO keeps the last issued command on the bus
    assign bus.alu_a  = empty ? lastA  : memA[rdPtr];
    assign bus.alu_b  = empty ? lastB  : memB[rdPtr];
    assign bus.alu_op = empty ? lastOp : memOp[rdPtr];

    always_ff @(posedge clk) begin
        if (push) begin
            memA[wrPtr]  <= bus.in_a;
            memB[wrPtr]  <= bus.in_b;
            memOp[wrPtr] <= bus.in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            tagCtr <= '0;
            tag_p1 <= '0;
            vld_p1 <= 1'b0;
            lastA  <= '0;
            lastB  <= '0;
            lastOp <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (issue) begin
                rdPtr  <= rdPtr + PTR_W'(1);
                tagCtr <= tagCtr + TAG_WIDTH'(1);
                tag_p1 <= tagCtr;
                lastA  <= memA[rdPtr];
                lastB  <= memB[rdPtr];
                lastOp <= memOp[rdPtr];
            end
            count  <= count + CNT_W'(push) - CNT_W'(issue);
            vld_p1 <= issue;
        end
    end

    // p1 -> p2: alu_result belongs to the command issued one cycle earlier
`ifdef ALU_ISSUE_STALL_EN
    logic [31:0]          resData_p2 [2];
    logic [TAG_WIDTH-1:0] resTag_p2  [2];
    logic                 resWr;
    logic                 resRd;
    logic                 resValid;
    logic                 resPop;
    logic [1:0]           resOcc;
    logic [2:0]           credit;

    assign resValid      = (resOcc != 2'd0);
    assign resPop        = resValid && bus.res_ready;
    // every issued command must find a result slot when it lands
    assign credit        = 3'(resOcc) + 3'(vld_p1) - 3'(resPop);
    assign creditOk      = (credit < 3'd2);
    assign bus.res_valid = resValid;
    assign bus.res_data  = resData_p2[resRd];
    assign bus.res_tag   = resTag_p2[resRd];

    always_ff @(posedge clk) begin
        if (rst) begin
            resWr  <= 1'b0;
            resRd  <= 1'b0;
            resOcc <= '0;
            for (int i = 0; i < 2; i++) begin
                resData_p2[i] <= '0;
                resTag_p2[i]  <= '0;
            end
        end else begin
            if (vld_p1) begin
                resData_p2[resWr] <= bus.alu_result;
                resTag_p2[resWr]  <= tag_p1;
                resWr             <= ~resWr;
            end
            if (resPop) resRd <= ~resRd;
            resOcc <= resOcc + 2'(vld_p1) - 2'(resPop);
        end
    end
`else
    logic                 vld_p2;
    logic [31:0]          data_p2;
    logic [TAG_WIDTH-1:0] tag_p2;

    assign creditOk      = 1'b1;
    assign bus.res_valid = vld_p2;
    assign bus.res_data  = data_p2;
    assign bus.res_tag   = tag_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            tag_p2  <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= bus.alu_result;
                tag_p2  <= tag_p1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: registered ALU model, ordered result scoreboard,
// vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_alu_issue_queue;
    localparam int DEPTH     = 4;
    localparam int TAG_WIDTH = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic [31:0]          data;
        logic [TAG_WIDTH-1:0] tag;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    int                   nChecks = 0;
    int                   nFails = 0;
    res_t                 expQ[$];
    res_t                 headRes;
    logic [TAG_WIDTH-1:0] nextTag = '0;
    logic [TAG_WIDTH-1:0] lastTag = '0;
    int                   resultsSeen = 0;
    bit                   accNow = 1'b0;
    bit                   held = 1'b0;
    bit                   consumed;
    logic [31:0]          heldData;
    logic [TAG_WIDTH-1:0] heldTag;
    vec_t                 vecs[8];
    logic [15:0]          bbA[6];
    logic [15:0]          bbB[6];
    logic [2:0]           bbOp[6];
    logic [31:0]          bbExp[6];
    int                   seen0;

    alu_issue_queue_if #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] aluFn(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        logic [31:0] xa;
        logic [31:0] xb;
        xa = {16'h0, a};
        xb = {16'h0, b};
        case (op)
            3'd0:    return xa + xb;
            3'd1:    return xa - xb;
            3'd2:    return xa ^ xb;
            3'd3:    return xa & xb;
            3'd4:    return xa | xb;
            3'd5:    return xa * xb;
            3'd6:    return xa << xb[4:0];
            default: return xa >> xb[4:0];
        endcase
    endfunction

    // ALU with one registered stage
    always @(posedge clk) bus.alu_result <= aluFn(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted command yields one result, in acceptance order
    always @(negedge clk) begin
        accNow = bus.in_valid && bus.in_ready;
        if (held) begin
            check("hold valid", 32'(bus.res_valid), 32'd1);
            check("hold data", bus.res_data, heldData);
            check("hold tag", 32'(bus.res_tag), 32'(heldTag));
        end
        held = 1'b0;
        if (bus.res_valid) begin
`ifdef ALU_ISSUE_STALL_EN
            consumed = bus.res_ready;
`else
            consumed = 1'b1;
`endif
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL spurious result: got data=0x%08h tag=%0d, required no result",
                         bus.res_data, bus.res_tag);
            end else begin
                headRes = expQ[0];
                check("result data", bus.res_data, headRes.data);
                check("result tag", 32'(bus.res_tag), 32'(headRes.tag));
                if (consumed) begin
                    void'(expQ.pop_front());
                    resultsSeen++;
                    lastTag = bus.res_tag;
                end else begin
                    held     = 1'b1;
                    heldData = bus.res_data;
                    heldTag  = bus.res_tag;
                end
            end
        end
        if (rst) begin
            expQ.delete();
            nextTag = '0;
            held    = 1'b0;
        end else if (accNow) begin
            expQ.push_back('{aluFn(bus.in_a, bus.in_b, bus.in_op), nextTag});
            nextTag++;
        end
    end

    task automatic newCmd();
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_op    = 3'($urandom);
        bus.in_valid = 1'b1;
    endtask

    task automatic waitEdge(input bit keep);
        @(posedge clk);
        #1;
        if (accNow) begin
            if (keep) newCmd();
            else bus.in_valid = 1'b0;
        end
    endtask

    task automatic doReset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("in_ready during rst", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset res_valid", 32'(bus.res_valid), 32'd0);
        check("post-reset fifo_count", 32'(bus.fifo_count), 32'd0);
        check("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // One command into an idle block: result must appear exactly in cycle 3
    task automatic runVector(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] op, input logic [31:0] expData,
                             input logic [TAG_WIDTH-1:0] expTag);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check({name, " res_valid@3"}, 32'(bus.res_valid), 32'd1);
                check({name, " res_data"}, bus.res_data, expData);
                check({name, " res_tag"}, 32'(bus.res_tag), 32'(expTag));
            end else begin
                check($sformatf("%s res_valid@%0d", name, c), 32'(bus.res_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendCmds(input int n, input bit randReady);
        int pushed = 0;
        int cyc = 0;
        while ((pushed < n || expQ.size() != 0) && cyc < 3000) begin
`ifdef ALU_ISSUE_STALL_EN
            bus.res_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
`endif
            if (!bus.in_valid && pushed < n && (!randReady || $urandom_range(0, 3) != 0))
                newCmd();
            @(posedge clk);
            #1;
            if (accNow) begin
                pushed++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
`ifdef ALU_ISSUE_STALL_EN
        bus.res_ready = 1'b1;
`endif
        check("commands accepted", 32'(pushed), 32'(n));
        check("results drained", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h0003, 16'h0004, 3'd0, 32'h0000_0007};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 3'd5, 32'hFFFE_0001};
        vecs[2] = '{16'h0001, 16'h000F, 3'd6, 32'h0000_8000};
        vecs[3] = '{16'h00F0, 16'h0FF0, 3'd2, 32'h0000_0F00};
        vecs[4] = '{16'h1234, 16'h00FF, 3'd3, 32'h0000_0034};
        vecs[5] = '{16'h1200, 16'h0034, 3'd4, 32'h0000_1234};
        vecs[6] = '{16'h8000, 16'h0004, 3'd7, 32'h0000_0800};
        vecs[7] = '{16'h0005, 16'h0007, 3'd1, 32'hFFFF_FFFE};

        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_op    = '0;
`ifdef ALU_ISSUE_STALL_EN
        bus.res_ready = 1'b1;
`endif
        doReset();
        @(negedge clk);
        check("reset alu_a", 32'(bus.alu_a), 32'd0);
        check("reset alu_b", 32'(bus.alu_b), 32'd0);
        check("reset alu_op", 32'(bus.alu_op), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                      vecs[i].expData, TAG_WIDTH'(i));
        @(negedge clk);
        check("idle alu_a holds last", 32'(bus.alu_a), 32'(vecs[7].a));
        check("idle alu_b holds last", 32'(bus.alu_b), 32'(vecs[7].b));
        check("idle alu_op holds last", 32'(bus.alu_op), 32'(vecs[7].op));
        @(posedge clk);
        #1;

        // six back-to-back commands: six consecutive results, tags 0..5
        doReset();
        bbA[0] = 16'hFFFF; bbB[0] = 16'hFFFF; bbOp[0] = 3'd5; bbExp[0] = 32'hFFFE_0001;
        bbA[1] = 16'h0001; bbB[1] = 16'h000F; bbOp[1] = 3'd6; bbExp[1] = 32'h0000_8000;
        for (int i = 2; i < 6; i++) begin
            bbA[i]   = 16'($urandom);
            bbB[i]   = 16'($urandom);
            bbOp[i]  = 3'($urandom);
            bbExp[i] = aluFn(bbA[i], bbB[i], bbOp[i]);
        end
        for (int t = 0; t < 10; t++) begin
            if (t < 6) begin
                bus.in_a     = bbA[t];
                bus.in_b     = bbB[t];
                bus.in_op    = bbOp[t];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (t >= 3 && t <= 8) begin
                check($sformatf("b2b res_valid %0d", t - 3), 32'(bus.res_valid), 32'd1);
                check($sformatf("b2b res_tag %0d", t - 3), 32'(bus.res_tag), 32'(t - 3));
                check($sformatf("b2b res_data %0d", t - 3), bus.res_data, bbExp[t - 3]);
            end else if (t == 9) begin
                check("b2b pulse ends", 32'(bus.res_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end

        // 17 issues: tag sequence wraps 15 -> 0
        doReset();
        seen0 = resultsSeen;
        sendCmds(17, 1'b0);
        check("17 results returned", 32'(resultsSeen - seen0), 32'd17);
        check("tag after wrap", 32'(lastTag), 32'd0);

        // reset with work queued and in flight
        doReset();
`ifdef ALU_ISSUE_STALL_EN
        bus.res_ready = 1'b0;
`endif
        for (int t = 0; t < 3; t++) begin
            newCmd();
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        doReset();
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("no stale result", 32'(bus.res_valid), 32'd0);
            @(posedge clk);
            #1;
        end
`ifdef ALU_ISSUE_STALL_EN
        bus.res_ready = 1'b1;
`endif
        runVector("after reset", 16'h0003, 16'h0004, 3'd0, 32'h0000_0007, '0);

`ifdef ALU_ISSUE_STALL_EN
        // backpressure fills result stage, then the command FIFO
        doReset();
        bus.res_ready = 1'b0;
        newCmd();
        repeat (12) waitEdge(1'b1);
        @(negedge clk);
        check("full fifo_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full in_ready", 32'(bus.in_ready), 32'd0);
        check("stalled res_valid", 32'(bus.res_valid), 32'd1);
        waitEdge(1'b1);
        bus.res_ready = 1'b1;
        waitEdge(1'b1);
        @(negedge clk);
        check("after pop fifo_count", 32'(bus.fifo_count), 32'(DEPTH - 1));
        check("after pop in_ready", 32'(bus.in_ready), 32'd1);
        waitEdge(1'b1);
        @(negedge clk);
        check("push+pop fifo_count", 32'(bus.fifo_count), 32'(DEPTH - 1));
        waitEdge(1'b0);
        bus.in_valid = 1'b0;
        sendCmds(0, 1'b0);

        // random res_ready over 50 commands
        doReset();
        seen0 = resultsSeen;
        sendCmds(50, 1'b1);
        check("50 results returned", 32'(resultsSeen - seen0), 32'd50);
`endif

        check("scoreboard empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
